// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Parity encoding, FSM state encoding and frame-length arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // cfg_parity code 3 is reserved and behaves as no parity
  function automatic parity_e decode_parity(input logic [1:0] p);
    case (p)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic int frame_bits(input int bpw, input parity_e par, input logic stop2);
    return 1 + bpw + ((par != PAR_NONE) ? 1 : 0) + (stop2 ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Valid/ready beat stream feeding the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int W_OUT = 16
) ();
  logic             s_valid;
  logic             s_ready;
  logic [W_OUT-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full flag and level count.
// Empty is derived from the registered level, so a beat is never read in its write cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full_q;
  assign do_rd   = rd_en && (level_q != '0);
  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = (level_q == '0);
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    if (do_wr && !do_rd)      level_d = level_q + LVL_ONE;
    else if (!do_wr && do_rd) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: beats are queued in a FIFO and serialised word by word,
// LSB word first, with per-beat latched baud divisor, parity and stop-bit count.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int W_OUT         = 16,
  parameter int BITS_PER_WORD = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int W_DIV         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_buffered_if.slave           s_if,
  input  logic [W_DIV-1:0]            cfg_div,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int BW        = $clog2(BITS_PER_WORD);
  localparam int WIW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [W_DIV-1:0] DIV_ONE = W_DIV'(1);
  localparam logic [W_DIV-1:0] DIV_MIN = W_DIV'(2);

  function automatic logic [W_DIV-1:0] sat_div(input logic [W_DIV-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  tx_state_e        state_q, state_d;
  logic [W_DIV-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIW-1:0]   word_q, word_d;
  logic             stop_q, stop_d;
  logic             tx_q, tx_d;
  logic             ready_q;
  logic [W_OUT-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic [W_DIV-1:0] div_q, div_d;
  parity_e          par_q, par_d;
  logic             stop2_q, stop2_d;

  logic             push, pop, bit_end;
  logic             fifo_full, fifo_empty;
  logic [W_OUT-1:0] head;
  logic [W_DIV-1:0] div_in;

  // ready is held low through reset and one edge beyond it
  assign s_if.s_ready = ready_q && !fifo_full;
  assign push         = s_if.s_valid && s_if.s_ready;
  assign div_in       = sat_div(cfg_div);
  assign bit_end      = (cnt_q == '0);
  assign tx           = tx_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (W_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (s_if.s_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    div_d   = div_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    pop     = 1'b0;

    if (state_q != ST_IDLE && !bit_end) cnt_d = cnt_q - DIV_ONE;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) pop = 1'b1;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        cnt_d   = div_q - DIV_ONE;
        bit_d   = '0;
        acc_d   = 1'b0;
        tx_d    = sh_q[0];
      end
      ST_DATA: if (bit_end) begin
        acc_d = acc_q ^ sh_q[0];
        sh_d  = sh_q >> 1;
        cnt_d = div_q - DIV_ONE;
        if (bit_q == BW'(BITS_PER_WORD - 1)) begin
          if (par_q == PAR_NONE) begin
            state_d = ST_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            state_d = ST_PARITY;
            tx_d    = (par_q == PAR_EVEN) ? acc_d : ~acc_d;
          end
        end else begin
          bit_d = bit_q + BW'(1);
          tx_d  = sh_q[1];
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        stop_d  = 1'b0;
        cnt_d   = div_q - DIV_ONE;
        tx_d    = 1'b1;
      end
      ST_STOP: if (bit_end) begin
        if (stop2_q && !stop_q) begin
          stop_d = 1'b1;
          cnt_d  = div_q - DIV_ONE;
        end else if (word_q != WIW'(NUM_WORDS - 1)) begin
          // next word of the same beat is already at the bottom of the shifter
          word_d  = word_q + WIW'(1);
          state_d = ST_START;
          cnt_d   = div_q - DIV_ONE;
          tx_d    = 1'b0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      sh_d    = head;
      div_d   = div_in;
      par_d   = decode_parity(cfg_parity);
      stop2_d = cfg_stop2;
      word_d  = '0;
      cnt_d   = div_in - DIV_ONE;
      state_d = ST_START;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    sh_q    <= sh_d;
    acc_q   <= acc_d;
    div_q   <= div_d;
    par_q   <= par_d;
    stop2_q <= stop2_d;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: vector table, stream/corner sequences and a mid-bit sampling monitor.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         div;
    parity_e    par;
    logic       stop2;
  } word_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] div;
    logic [1:0]  par;
    logic        stop2;
    int          exp_cyc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_push_cyc = 0;
  word_t exp_q[$];
  vec_t  vecs[7];

  uart_tx_buffered_if #(.W_OUT(16)) s_if ();

  uart_tx_buffered #(
    .W_OUT         (16),
    .BITS_PER_WORD (8),
    .FIFO_DEPTH    (4),
    .W_DIV         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (s_if),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endfunction

  task automatic enqueue(input logic [15:0] d);
    word_t w;
    for (int k = 0; k < 2; k++) begin
      w.data  = d[k*8 +: 8];
      w.div   = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
      w.par   = (cfg_parity == 2'd1) ? PAR_EVEN : (cfg_parity == 2'd2) ? PAR_ODD : PAR_NONE;
      w.stop2 = cfg_stop2;
      exp_q.push_back(w);
    end
  endtask

  task automatic push_beat(input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    while (!s_if.s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!s_if.s_ready) check("push_timeout", 0, 1);
    else enqueue(d);
    @(posedge clk);
    #1;
    last_push_cyc = cyc;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 16'($urandom);
  endtask

  task automatic wait_idle(output int when);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 20000);
    if (busy) check("idle_timeout", 1, 0);
    when = cyc;
  endtask

  // Monitor: detects each start bit and samples every bit at its centre using the expected divisor.
  initial begin : monitor
    word_t w;
    int nb;
    logic [11:0] expv, actv;
    logic aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          while (tx === 1'b0) @(negedge clk);
        end else begin
          w  = exp_q.pop_front();
          nb = 1 + 8 + ((w.par != PAR_NONE) ? 1 : 0) + (w.stop2 ? 2 : 1);
          expv = '0;
          actv = '0;
          for (int i = 0; i < 8; i++) expv[1+i] = w.data[i];
          if (w.par == PAR_EVEN) expv[9] = ^w.data;
          if (w.par == PAR_ODD)  expv[9] = ~^w.data;
          for (int i = ((w.par != PAR_NONE) ? 10 : 9); i < nb; i++) expv[i] = 1'b1;
          aborted = 1'b0;
          for (int k = 0; k < nb && !aborted; k++) begin
            for (int c = 0; c < w.div && !aborted; c++) begin
              if (k > 0 || c > 0) @(negedge clk);
              if (rst) aborted = 1'b1;
              else if (c == w.div / 2) actv[k] = tx;
            end
          end
          if (!aborted) check("frame", int'(actv), int'(expv));
        end
      end
    end
  end

  initial begin : main
    int t, t0, n_bad, grp, sent;
    rst          = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    cfg_div      = 16'd4;
    cfg_parity   = 2'd0;
    cfg_stop2    = 1'b0;

    vecs[0] = '{16'hA53C, 16'd4, 2'd0, 1'b0, 81};
    vecs[1] = '{16'h0707, 16'd4, 2'd1, 1'b0, 89};
    vecs[2] = '{16'h0707, 16'd4, 2'd2, 1'b1, 97};
    vecs[3] = '{16'h00FF, 16'd0, 2'd0, 1'b0, 41};
    vecs[4] = '{16'h8001, 16'd1, 2'd1, 1'b1, 49};
    vecs[5] = '{16'h1234, 16'd3, 2'd2, 1'b0, 67};
    vecs[6] = '{16'hFFFF, 16'd5, 2'd3, 1'b1, 111};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(s_if.s_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(fifo_level), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_rst", int'(s_if.s_ready), 1);
    check("idle_tx", int'(tx), 1);

    // Single beats, one per config, from an idle transmitter
    for (int i = 0; i < 7; i++) begin
      cfg_div    = vecs[i].div;
      cfg_parity = vecs[i].par;
      cfg_stop2  = vecs[i].stop2;
      push_beat(vecs[i].data);
      check($sformatf("vec%0d_tx_hold", i), int'(tx), 1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_tx_fall", i), int'(tx), 0);
      wait_idle(t);
      check($sformatf("vec%0d_cycles", i), t - last_push_cyc, vecs[i].exp_cyc);
    end

    // Six beats streamed back to back: five fit before ready drops
    cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    t0 = 0;
    for (int b = 0; b < 6; b++) begin
      push_beat(16'h1111 * 16'(b + 1));
      if (b == 0) t0 = last_push_cyc;
      if (b == 4) begin
        check("full_ready", int'(s_if.s_ready), 0);
        check("full_level", int'(fifo_level), 4);
      end
    end
    wait_idle(t);
    check("stream_cycles", t - t0, 481);

    // Divisor change while a beat is on the line only affects the next beat
    push_beat(16'h3C5A);
    t0 = last_push_cyc;
    repeat (10) @(posedge clk);
    #1;
    cfg_div = 16'd8;
    push_beat(16'hF00F);
    wait_idle(t);
    check("div_change_cycles", t - t0, 241);

    // Reset in the middle of word 1 with two beats still queued
    cfg_div = 16'd4;
    push_beat(16'h00C3);
    t0 = last_push_cyc;
    push_beat(16'hBEEF);
    push_beat(16'hCAFE);
    repeat (48) @(posedge clk);
    #2;
    check("pre_rst_tx", int'(tx), 0);
    check("pre_rst_level", int'(fifo_level), 2);
    rst = 1'b1;
    #1;
    check("async_rst_tx", int'(tx), 1);
    check("async_rst_level", int'(fifo_level), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) n_bad++;
    end
    check("no_resume", n_bad, 0);
    push_beat(16'h5AA5);
    wait_idle(t);
    check("post_rst_cycles", t - last_push_cyc, 81);

    // Randomised groups: config changes only while the transmitter is idle
    sent = 0;
    while (sent < 200) begin
      cfg_div    = 16'($urandom_range(0, 6));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      grp = $urandom_range(1, 4);
      if (grp > 200 - sent) grp = 200 - sent;
      for (int g = 0; g < grp; g++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        push_beat(16'($urandom));
        sent++;
      end
      wait_idle(t);
    end
    repeat (4) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
